// File: rtl/f_fetch_pc.sv
// Fetch-stage PC register and next-PC selection.
// Owns the F-stage fetch address, drives the imem fetch handshake and applies
// D-stage redirects after the single branch delay slot. A redirect that
// resolves while the delay-slot fetch is still outstanding is parked in a
// pending-target register and applied once that fetch completes.
module f_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_Stall,
  input  logic        D_Valid,
  input  logic [1:0]  D_NPCOp,
  input  logic        CMP_Result,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_Imm16,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RsData,
  input  logic        F_Ready,
  output logic [31:0] F_PC,
  output logic        F_Req,
  output logic        F_Valid,
  output logic        F_Redirect
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  state_t      state;
  logic [31:0] pend;

  logic               redir;
  logic signed [31:0] br_off;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic [31:0]        target;

  // Redirect decision and target selection for the D-stage instruction
  always_comb begin
    redir     = 1'b0;
    br_off    = {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
    br_target = D_PC + 32'd4 + br_off;
    j_target  = {D_PC[31:28], D_Imm26, 2'b00};
    target    = br_target;
    if (D_Valid && !D_Stall) begin
      unique case (D_NPCOp)
        NPC_SEQ: redir = 1'b0;
        NPC_BR:  redir = CMP_Result;
        NPC_J:   redir = 1'b1;
        NPC_JR:  redir = 1'b1;
        default: redir = 1'b0;
      endcase
    end
    unique case (D_NPCOp)
      NPC_J:   target = j_target;
      NPC_JR:  target = D_RsData;
      default: target = br_target;
    endcase
  end

  // Handshake outputs; all forced low while reset is held
  always_comb begin
    F_Req      = ~reset;
    F_Valid    = ~reset & F_Ready & ~D_Stall;
    F_Redirect = 1'b0;
    if (!reset) begin
      if (state == RUN)
        F_Redirect = redir;
      else
        F_Redirect = F_Ready & ~D_Stall;
    end
  end

  // PC / pending-target state machine; redirects wait behind the delay slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      F_PC  <= RESET_PC;
      pend  <= 32'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (D_Stall) begin
            state <= RUN;
          end else if (F_Ready) begin
            F_PC <= redir ? target : F_PC + 32'd4;
          end else if (redir) begin
            pend  <= target;
            state <= PEND;
          end
        end
        PEND: begin
          if (F_Ready && !D_Stall) begin
            F_PC  <= pend;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_pc.sv
// Directed table-driven bench for the fetch-stage PC unit.
module tb_f_fetch_pc;

  logic        clk;
  logic        reset;
  logic        D_Stall;
  logic        D_Valid;
  logic [1:0]  D_NPCOp;
  logic        CMP_Result;
  logic [31:0] D_PC;
  logic [15:0] D_Imm16;
  logic [25:0] D_Imm26;
  logic [31:0] D_RsData;
  logic        F_Ready;
  logic [31:0] F_PC;
  logic        F_Req;
  logic        F_Valid;
  logic        F_Redirect;

  int n_chk;
  int n_fail;

  f_fetch_pc #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_Stall    (D_Stall),
    .D_Valid    (D_Valid),
    .D_NPCOp    (D_NPCOp),
    .CMP_Result (CMP_Result),
    .D_PC       (D_PC),
    .D_Imm16    (D_Imm16),
    .D_Imm26    (D_Imm26),
    .D_RsData   (D_RsData),
    .F_Ready    (F_Ready),
    .F_PC       (F_PC),
    .F_Req      (F_Req),
    .F_Valid    (F_Valid),
    .F_Redirect (F_Redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          dv;
    bit          st;
    bit [1:0]    op;
    bit          cmp;
    bit          rdy;
    bit [31:0]   dpc;
    bit [15:0]   imm16;
    bit [25:0]   imm26;
    bit [31:0]   rs;
    bit [31:0]   e_pc;
    bit          e_fv;
    bit          e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit dv, bit st, bit [1:0] op, bit cmp, bit rdy,
                              bit [31:0] dpc, bit [15:0] imm16, bit [25:0] imm26,
                              bit [31:0] rs, bit [31:0] e_pc, bit e_fv, bit e_rd);
    vec_t v;
    v.rst = rst; v.dv = dv; v.st = st; v.op = op; v.cmp = cmp; v.rdy = rdy;
    v.dpc = dpc; v.imm16 = imm16; v.imm26 = imm26; v.rs = rs;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    D_Stall = 1'b0; D_Valid = 1'b1; D_NPCOp = 2'd0; CMP_Result = 1'b0;
    D_PC = 32'd0; D_Imm16 = 16'd0; D_Imm26 = 26'd0; D_RsData = 32'd0;
    F_Ready = 1'b1;
  endtask

  // Assert reset for one cycle (F_Ready high to show it is masked)
  task automatic do_reset(input int idx);
    @(negedge clk);
    reset = 1'b1;
    drive_nop();
    #1;
    check($sformatf("rst%0d_pc", idx), F_PC, 32'h0000_3000);
    check($sformatf("rst%0d_req", idx), {31'd0, F_Req}, 32'd0);
    check($sformatf("rst%0d_fvalid", idx), {31'd0, F_Valid}, 32'd0);
    check($sformatf("rst%0d_redir", idx), {31'd0, F_Redirect}, 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("rst%0d_pc_hold", idx), F_PC, 32'h0000_3000);
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    reset      = 1'b0;
    D_Valid    = v.dv;
    D_Stall    = v.st;
    D_NPCOp    = v.op;
    CMP_Result = v.cmp;
    F_Ready    = v.rdy;
    D_PC       = v.dpc;
    D_Imm16    = v.imm16;
    D_Imm26    = v.imm26;
    D_RsData   = v.rs;
    #1;
    check($sformatf("v%0d_req", idx), {31'd0, F_Req}, 32'd1);
    check($sformatf("v%0d_fvalid", idx), {31'd0, F_Valid}, {31'd0, v.e_fv});
    check($sformatf("v%0d_redir", idx), {31'd0, F_Redirect}, {31'd0, v.e_rd});
    @(posedge clk);
    #1;
    check($sformatf("v%0d_pc", idx), F_PC, v.e_pc);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive_nop();

    //          rst dv st op cmp rdy dpc           imm16     imm26        rs            e_pc         fv rd
    // sequential fetch after reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        32'h3004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3000,     16'h0,    26'h0,       32'h0,        32'h3008, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3004,     16'h0,    26'h0,       32'h0,        32'h300C, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3008,     16'h0,    26'h0,       32'h0,        32'h3010, 1, 0));
    // restart, then beq taken at 3004 -> delay slot 3008, then 3000
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        32'h3004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3000,     16'h0,    26'h0,       32'h0,        32'h3008, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 32'h3004,     16'hFFFE, 26'h0,       32'h0,        32'h3000, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3008,     16'h0,    26'h0,       32'h0,        32'h3004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3000,     16'h0,    26'h0,       32'h0,        32'h3008, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3004,     16'h0,    26'h0,       32'h0,        32'h300C, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3008,     16'h0,    26'h0,       32'h0,        32'h3010, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h300C,     16'h0,    26'h0,       32'h0,        32'h3014, 1, 0));
    // bne not taken at 3010: sequential
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 32'h3010,     16'h0040, 26'h0,       32'h0,        32'h3018, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3014,     16'h0,    26'h0,       32'h0,        32'h301C, 1, 0));
    // jr 3100 while delay-slot fetch stalls on imem for 3 cycles
    tbl.push_back(mk(0, 1, 0, 3, 0, 0, 32'h3018,     16'h0,    26'h0,       32'h3100,     32'h301C, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h301C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h301C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        32'h3100, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h301C,     16'h0,    26'h0,       32'h0,        32'h3104, 1, 0));
    // j 0xC40 held off by a 2-cycle stall, applied when stall drops
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 32'h3100,     16'h0,    26'h0000C40, 32'h0,        32'h3104, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 32'h3100,     16'h0,    26'h0000C40, 32'h0,        32'h3104, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0, 1, 32'h3100,     16'h0,    26'h0000C40, 32'h0,        32'h3100, 1, 1));
    // enter PEND with target 3100, then reset discards it
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3104,     16'h0,    26'h0,       32'h0,        32'h3104, 1, 0));
    tbl.push_back(mk(0, 1, 0, 3, 0, 0, 32'h3100,     16'h0,    26'h0,       32'h3100,     32'h3104, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        32'h3004, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3000,     16'h0,    26'h0,       32'h0,        32'h3008, 1, 0));
    // unaligned jr target passes through untouched
    tbl.push_back(mk(0, 1, 0, 3, 0, 1, 32'h3004,     16'h0,    26'h0,       32'h0000_3102, 32'h3102, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h3008,     16'h0,    26'h0,       32'h0,        32'h3106, 1, 0));
    // bubble with taken-looking branch fields and imem not ready: nothing moves
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h3102,     16'h0004, 26'h0,       32'h0,        32'h3106, 0, 0));
    // forward branch: 3106 + 0x10
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 32'h3102,     16'h0004, 26'h0,       32'h0,        32'h3116, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset(i);
      apply(i, tbl[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
